// File: rtl/axil_cfg_pkg.sv
// Shared definitions for the FIR configuration slave: register offsets, ap_ctrl bit
// positions and the read-channel state encoding.
package axil_cfg_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h00;
  localparam int unsigned ADDR_DATA_LEN = 32'h10;
  localparam int unsigned ADDR_TAP_BASE = 32'h40;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  typedef enum logic [0:0] {
    RIdle = 1'b0,
    RData = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axil_cfg_slave_if.sv
// AXI-Lite configuration bus between the Wishbone bridge (master) and the FIR config
// slave. There is no B channel and there are no response codes.
interface axil_cfg_slave_if #(
  parameter int unsigned AddrW = 12,
  parameter int unsigned DataW = 32
);
  logic             awvalid;
  logic             awready;
  logic [AddrW-1:0] awaddr;
  logic             wvalid;
  logic             wready;
  logic [DataW-1:0] wdata;
  logic             arvalid;
  logic             arready;
  logic [AddrW-1:0] araddr;
  logic             rvalid;
  logic             rready;
  logic [DataW-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/axil_cfg_tapbank.sv
// Tap-coefficient storage: one synchronous write port and two combinational read
// ports (bus side and FIR engine side). Out-of-range read indices return zero.
module axil_cfg_tapbank #(
  parameter int unsigned TapNum = 11,
  parameter int unsigned DataW  = 32,
  parameter int unsigned IdxW   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IdxW-1:0]  widx,
  input  logic [DataW-1:0] wdata,
  input  logic [IdxW-1:0]  bus_idx,
  output logic [DataW-1:0] bus_rdata,
  input  logic [IdxW-1:0]  eng_idx,
  output logic [DataW-1:0] eng_rdata
);

  logic [DataW-1:0] taps_q [TapNum];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TapNum; i++) taps_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < TapNum; i++) begin
        if (widx == IdxW'(i)) taps_q[i] <= wdata;
      end
    end
  end

  // Compare against each slot so indices past the bank fall through to zero.
  always_comb begin
    bus_rdata = '0;
    eng_rdata = '0;
    for (int i = 0; i < TapNum; i++) begin
      if (bus_idx == IdxW'(i)) bus_rdata = taps_q[i];
      if (eng_idx == IdxW'(i)) eng_rdata = taps_q[i];
    end
  end

endmodule

// File: rtl/axil_cfg_slave.sv
// FIR configuration slave: ap_ctrl, data_length and tap bank behind an AXI-Lite port.
// Define AXIL_TAP_LOCK_EN to drop tap/data_length writes while the engine is busy.
module axil_cfg_slave
  import axil_cfg_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pTAP_NUM    = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  axil_cfg_slave_if.slave        bus,
  output logic                   eng_start,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] data_length,
  input  logic [3:0]             tap_idx,
  output logic [pDATA_WIDTH-1:0] tap_coef
);

  localparam logic [pADDR_WIDTH-1:0] CtrlAddr = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] LenAddr  = pADDR_WIDTH'(ADDR_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] TapBase  = pADDR_WIDTH'(ADDR_TAP_BASE);

  function automatic logic [pADDR_WIDTH-1:0] tap_index(input logic [pADDR_WIDTH-1:0] a);
    logic [pADDR_WIDTH-1:0] off;
    off = a - TapBase;
    return off >> 2;
  endfunction

  function automatic logic tap_hit(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TapBase) && (a[1:0] == 2'b00) &&
           (tap_index(a) < pADDR_WIDTH'(pTAP_NUM));
  endfunction

  // Write channel holds
  logic                   aw_full_q, w_full_q;
  logic [pADDR_WIDTH-1:0] aw_addr_q;
  logic [pDATA_WIDTH-1:0] w_data_q;
  logic                   aw_hs, w_hs, commit;

  // ap_ctrl / data_length state
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
  logic                   cfg_lock;

  // Read channel
  rd_state_e              rd_state_q, rd_state_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [pDATA_WIDTH-1:0] rd_mux;
  logic                   ar_hs, rd_ctrl_hs;

  logic                   wr_ctrl, wr_len, wr_tap;
  logic [pDATA_WIDTH-1:0] tap_bus_rdata;

  // Both holds full means this is the commit cycle; ready reopens for the next beat.
  assign commit      = aw_full_q & w_full_q;
  assign bus.awready = ~aw_full_q | commit;
  assign bus.wready  = ~w_full_q | commit;
  assign aw_hs       = bus.awvalid & bus.awready;
  assign w_hs        = bus.wvalid & bus.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= bus.awaddr;
      end else if (commit) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= bus.wdata;
      end else if (commit) begin
        w_full_q <= 1'b0;
      end
    end
  end

  assign wr_ctrl = commit && (aw_addr_q == CtrlAddr);
  assign wr_len  = commit && (aw_addr_q == LenAddr);
  assign wr_tap  = commit && tap_hit(aw_addr_q);

`ifdef AXIL_TAP_LOCK_EN
  assign cfg_lock = ~ap_idle_q;
`else
  assign cfg_lock = 1'b0;
`endif

  always_comb begin
    ap_start_d    = 1'b0;
    ap_done_d     = ap_done_q;
    ap_idle_d     = ap_idle_q;
    data_length_d = data_length_q;
    if (rd_ctrl_hs) ap_done_d = 1'b0;
    if (wr_ctrl && w_data_q[AP_START_BIT] && ap_idle_q) begin
      ap_start_d = 1'b1;
      ap_idle_d  = 1'b0;
    end
    // A finishing engine outranks the read-to-clear of ap_done.
    if (eng_done) begin
      ap_done_d = 1'b1;
      ap_idle_d = 1'b1;
    end
    if (wr_len && !cfg_lock) data_length_d = w_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ap_start_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      ap_idle_q     <= 1'b1;
      data_length_q <= '0;
    end else begin
      ap_start_q    <= ap_start_d;
      ap_done_q     <= ap_done_d;
      ap_idle_q     <= ap_idle_d;
      data_length_q <= data_length_d;
    end
  end

  assign eng_start   = ap_start_q;
  assign data_length = data_length_q;

  axil_cfg_tapbank #(
    .TapNum (pTAP_NUM),
    .DataW  (pDATA_WIDTH),
    .IdxW   (pADDR_WIDTH)
  ) u_tapbank (
    .clk       (clk),
    .rst       (rst),
    .we        (wr_tap && !cfg_lock),
    .widx      (tap_index(aw_addr_q)),
    .wdata     (w_data_q),
    .bus_idx   (tap_index(bus.araddr)),
    .bus_rdata (tap_bus_rdata),
    .eng_idx   ({{(pADDR_WIDTH-4){1'b0}}, tap_idx}),
    .eng_rdata (tap_coef)
  );

  always_comb begin
    rd_mux = '0;
    if (bus.araddr == CtrlAddr) begin
      rd_mux[AP_START_BIT] = ap_start_q;
      rd_mux[AP_DONE_BIT]  = ap_done_q;
      rd_mux[AP_IDLE_BIT]  = ap_idle_q;
    end else if (bus.araddr == LenAddr) begin
      rd_mux = data_length_q;
    end else if (tap_hit(bus.araddr)) begin
      rd_mux = tap_bus_rdata;
    end
  end

  assign bus.arready = (rd_state_q == RIdle);
  assign bus.rvalid  = (rd_state_q == RData);
  assign bus.rdata   = rdata_q;
  assign ar_hs       = bus.arvalid & bus.arready;
  assign rd_ctrl_hs  = ar_hs && (bus.araddr == CtrlAddr);

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      RIdle: begin
        if (bus.arvalid) begin
          rd_state_d = RData;
          rdata_d    = rd_mux;
        end
      end
      RData: begin
        if (bus.rready) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RIdle;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axil_cfg_slave.sv
// Scoreboard bench for axil_cfg_slave: directed scenarios followed by random register
// traffic, all read data checked against a register-map model by a separate monitor.
module tb_axil_cfg_slave;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NTAP = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          eng_start;
  logic          eng_done;
  logic [DW-1:0] data_length;
  logic [3:0]    tap_idx;
  logic [DW-1:0] tap_coef;

  always #5 clk = ~clk;

  axil_cfg_slave_if #(.AddrW(AW), .DataW(DW)) bus ();

  axil_cfg_slave #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .pTAP_NUM    (NTAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .data_length (data_length),
    .tap_idx     (tap_idx),
    .tap_coef    (tap_coef)
  );

  int n_checks = 0;
  int n_pass = 0;
  int n_start_seen = 0;
  logic [31:0] exp_q[$];

  // Reference register map
  logic [31:0] m_tap[NTAP];
  logic [31:0] m_len;
  bit          m_idle, m_done, lock_en;
  int          m_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  function automatic bit is_tap(input int a);
    return a >= 'h40 && (a % 4) == 0 && (a - 'h40) / 4 < NTAP;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NTAP; i++) m_tap[i] = 0;
    m_len = 0;
    m_idle = 1;
    m_done = 0;
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    bit busy_locked;
    busy_locked = lock_en && !m_idle;
    if (a == 0) begin
      if (d[0] && m_idle) begin
        m_idle = 0;
        m_starts++;
      end
    end else if (a == 'h10) begin
      if (!busy_locked) m_len = d;
    end else if (is_tap(a)) begin
      if (!busy_locked) m_tap[(a - 'h40) / 4] = d;
    end
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = 0;
    if (a == 0) begin
      v[2] = m_idle;
      v[1] = m_done;
      m_done = 0;
    end else if (a == 'h10) v = m_len;
    else if (is_tap(a)) v = m_tap[(a - 'h40) / 4];
    return v;
  endfunction

  // Monitor: every completing R beat is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rvalid && bus.rready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rdata_unexpected: got %h expected no response", bus.rdata);
      end else begin
        check("rdata", bus.rdata, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) if (rst === 1'b0 && eng_start) n_start_seen++;

  task automatic send_aw(input logic [AW-1:0] a);
    int t;
    @(negedge clk);
    bus.awvalid = 1'b1;
    bus.awaddr = a;
    t = 0;
    while (!bus.awready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) fail_timeout("awready");
    @(posedge clk); #1 bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d);
    int t;
    @(negedge clk);
    bus.wvalid = 1'b1;
    bus.wdata = d;
    t = 0;
    while (!bus.wready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) fail_timeout("wready");
    @(posedge clk); #1 bus.wvalid = 1'b0;
  endtask

  // order 0: AW and W together; 1: AW first; 2: W first.
  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int order,
                       input int gap);
    int t;
    if (order == 0) begin
      @(negedge clk);
      bus.awvalid = 1'b1; bus.awaddr = a;
      bus.wvalid = 1'b1;  bus.wdata = d;
      t = 0;
      while (!(bus.awready && bus.wready) && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) fail_timeout("aw_w_ready");
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end else if (order == 1) begin
      send_aw(a);
      check("awready_held_low", bus.awready, 1'b0);
      repeat (gap) @(negedge clk);
      send_w(d);
    end else begin
      send_w(d);
      check("wready_held_low", bus.wready, 1'b0);
      repeat (gap) @(negedge clk);
      send_aw(a);
    end
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_commit", {bus.awready, bus.wready}, 2'b11);
    model_write(int'(a), d);
    check("eng_start_pulses", n_start_seen, m_starts);
  endtask

  task automatic read(input logic [AW-1:0] a, input int hold, input bit with_done);
    int t;
    logic [31:0] e;
    @(negedge clk);
    bus.araddr = a;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) fail_timeout("arready");
    if (with_done) eng_done = 1'b1;
    e = model_read(int'(a));
    exp_q.push_back(e);
    if (with_done) begin m_done = 1; m_idle = 1; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    eng_done = 1'b0;
    @(negedge clk);
    check("rvalid_latency", bus.rvalid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", bus.rvalid, 1'b1);
      check("rdata_hold", bus.rdata, e);
      check("arready_busy", bus.arready, 1'b0);
    end
    @(posedge clk); #1 bus.rready = 1'b1;
    @(posedge clk); #1 bus.rready = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    eng_done = 1'b1;
    @(posedge clk); #1 eng_done = 1'b0;
    m_done = 1;
    m_idle = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int op, k;
`ifdef AXIL_TAP_LOCK_EN
    lock_en = 1;
`else
    lock_en = 0;
`endif
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    eng_done = 0; tap_idx = 0;
    do_reset();

    @(negedge clk);
    check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_data_length", data_length, 32'h0);
    check("rst_tap_coef", tap_coef, 32'h0);

    read(12'h000, 0, 0);
    write(12'h040, 32'h0000_0005, 1, 2);
    write(12'h044, 32'hFFFF_FFFE, 2, 1);
    read(12'h040, 0, 0);
    read(12'h044, 0, 0);
    tap_idx = 4'd1; #1 check("tap_coef_1", tap_coef, 32'hFFFF_FFFE);
    tap_idx = 4'd11; #1 check("tap_coef_oob11", tap_coef, 32'h0);
    tap_idx = 4'd15; #1 check("tap_coef_oob15", tap_coef, 32'h0);

    write(12'h010, 32'd600, 0, 0);
    check("data_length", data_length, 32'd600);
    write(12'h000, 32'h1, 0, 0);
    read(12'h000, 0, 0);
    write(12'h000, 32'h1, 1, 0);
    write(12'h048, 32'd7, 0, 0);
    read(12'h048, 0, 0);

    pulse_done();
    read(12'h000, 0, 0);
    read(12'h000, 0, 0);
    write(12'h000, 32'h7, 2, 0);
    read(12'h000, 0, 1);
    read(12'h000, 0, 0);
    read(12'h000, 0, 0);
    read(12'h010, 5, 0);
    write(12'h020, 32'hDEAD_BEEF, 0, 0);
    read(12'h020, 0, 0);
    write(12'h06C, 32'h1234_5678, 0, 0);
    read(12'h06C, 1, 0);

    // Reset in the middle of a half-done write and an outstanding read.
    send_aw(12'h010);
    @(negedge clk);
    bus.araddr = 12'h040; bus.arvalid = 1'b1;
    @(posedge clk); #1 bus.arvalid = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_mid_rvalid", bus.rvalid, 1'b0);
    check("rst_mid_awready", bus.awready, 1'b1);
    send_w(32'h0000_ABCD);
    send_aw(12'h044);
    repeat (2) @(posedge clk);
    #1 model_write('h44, 32'h0000_ABCD);
    read(12'h010, 0, 0);
    read(12'h044, 0, 0);

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      k = $urandom_range(0, 9);
      if (k < 5) ra = AW'('h40 + 4 * $urandom_range(0, NTAP - 1));
      else if (k < 7) ra = 12'h010;
      else if (k < 8) ra = 12'h000;
      else begin
        case ($urandom_range(0, 4))
          0: ra = 12'h004;
          1: ra = 12'h03C;
          2: ra = 12'h041;
          3: ra = 12'h070;
          default: ra = 12'h100;
        endcase
      end
      rd = $urandom;
      if (op <= 3) begin
        write(ra, rd, $urandom_range(0, 2), $urandom_range(0, 3));
      end else if (op <= 7) begin
        read(ra, $urandom_range(0, 2), !m_idle && $urandom_range(0, 3) == 0);
      end else if (op == 8) begin
        if (!m_idle) pulse_done();
      end else begin
        k = $urandom_range(0, 15);
        tap_idx = 4'(k);
        #1 check("tap_coef_rand", tap_coef, (k < NTAP) ? m_tap[k] : 32'h0);
        check("data_length_rand", data_length, m_len);
      end
    end

    repeat (4) @(posedge clk);
    #1 check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
